// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared types for the UART tx scheduler.
// State encoding and requester-count limits.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } sched_state_t;

    localparam int N_REQ_MAX = 8;
    localparam int ID_W      = $clog2(N_REQ_MAX);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// First set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          found
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // scan N positions starting at ptr; first hit wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter among N_REQ
// byte producers with round-robin grants.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic                      txclk,
    input  logic                      reset,
    input  logic                      sched_en,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      ld_tx_data,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_enable,
    input  logic                      tx_empty,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      err_timeout
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(LOAD_TIMEOUT + 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [GW-1:0]     rr_ptr;
    logic [N_REQ-1:0]  win_oh;
    logic              found;
    logic [ID_W-1:0]   win_id;
    logic [DATA_W-1:0] win_data;
    logic [CW-1:0]     cnt;
    logic              start;
    logic              tmo;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (GW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (win_oh),
        .found (found)
    );

    // winner index and byte from the one-hot grant
    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_id   = ID_W'(i);
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign start = sched_en & tx_empty & found;
    assign tmo   = tx_empty &&
                   (cnt == CW'(LOAD_TIMEOUT - 1));

    // next-state decode; also feeds busy/tx_enable registers
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start) state_nxt = LOAD;
            LOAD:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!tx_empty) state_nxt = WAIT_DONE;
                else if (tmo)  state_nxt = IDLE;
            end
            WAIT_DONE: if (tx_empty) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // state, pointer, timeout counter and registered outputs
    always_ff @(posedge txclk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            req_ack     <= '0;
            ld_tx_data  <= 1'b0;
            tx_data     <= '0;
            tx_enable   <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            tx_enable  <= sched_en | (state_nxt != IDLE);
            req_ack    <= '0;
            ld_tx_data <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_data    <= win_data;
                        grant_id   <= win_id[GW-1:0];
                        req_ack    <= win_oh;
                        ld_tx_data <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (grant_id == GW'(N_REQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant_id + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_empty) begin
                        if (tmo) err_timeout <= 1'b1;
                        else     cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench with a small
// transmitter model and directed requester scenarios.
module tb_uart_tx_sched;

    logic        txclk;
    logic        reset;
    logic        sched_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        ld_tx_data;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_empty;
    logic        busy;
    logic [1:0]  grant_id;
    logic        err_timeout;

    uart_tx_sched #(
        .N_REQ        (4),
        .DATA_W       (8),
        .LOAD_TIMEOUT (15)
    ) dut (
        .txclk       (txclk),
        .reset       (reset),
        .sched_en    (sched_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_empty    (tx_empty),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    // requester i: valid while sent < quota, data = base + bytes sent
    int         sent  [4];
    int         quota [4];
    int         off   [4];
    logic [7:0] base  [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = sent[i] < quota[i];
            req_data[i*8 +: 8]  = base[i] + 8'(sent[i] - off[i]);
        end
    end

    // transmitter model: empty falls after a load, rises
    // after 10 enabled cycles; stuck suppresses the fall
    logic       stuck;
    logic [3:0] mcnt;
    always @(posedge txclk) begin
        if (reset) begin
            tx_empty <= 1'b1;
            mcnt     <= '0;
        end else if (ld_tx_data && !stuck) begin
            tx_empty <= 1'b0;
            mcnt     <= '0;
        end else if (!tx_empty && tx_enable) begin
            if (mcnt == 4'd9) tx_empty <= 1'b1;
            else              mcnt <= mcnt + 4'd1;
        end
    end

    int checks;
    int errors;
    logic [11:0] exp_q [$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2i(input logic [3:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic push(input logic [3:0] a,
                        input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic give(input int i, input int k,
                        input logic [7:0] b);
        off[i]   = sent[i];
        base[i]  = b;
        quota[i] = sent[i] + k;
    endtask

    // monitor: every ack/load pops the scoreboard
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge txclk);
            if (req_ack != 4'd0 || ld_tx_data) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack",
                          {23'd0, req_ack, ld_tx_data, tx_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", 32'(req_ack), 32'(e[11:8]));
                    check("tx_data", 32'(tx_data), 32'(e[7:0]));
                    check("ld_tx_data", 32'(ld_tx_data), 1);
                    check("grant_id", 32'(grant_id),
                          32'(oh2i(e[11:8])));
                end
                for (int i = 0; i < 4; i++)
                    if (req_ack[i]) sent[i]++;
            end
        end
    end

    function automatic logic [31:0] outs();
        return 32'({req_ack, ld_tx_data, tx_enable, busy,
                    err_timeout, tx_data, grant_id});
    endfunction

    function automatic bit all_sent();
        bit r;
        r = 1'b1;
        for (int i = 0; i < 4; i++)
            if (sent[i] != quota[i]) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge txclk);
            n++;
        end while (!(exp_q.size() == 0 && !busy && all_sent())
                   && n < 400);
        check(name, 32'(exp_q.size()), 0);
        check({name, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge txclk);
        reset = 1'b1;
        @(negedge txclk);
        reset = 1'b0;
    endtask

    task automatic wait_frame_start();
        int n;
        n = 0;
        while (tx_empty && n < 30) begin
            @(negedge txclk);
            n++;
        end
        check("frame_started", 32'(tx_empty), 0);
    endtask

    int n, len, cyc, bad, acks;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        sched_en = 1'b1;
        stuck    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            off[i]  = 0;
        end
        give(0, 1, 8'h00);
        give(1, 1, 8'h10);
        give(2, 1, 8'h20);
        give(3, 1, 8'h30);
        push(4'b0001, 8'h00);
        push(4'b0010, 8'h10);
        push(4'b0100, 8'h20);
        push(4'b1000, 8'h30);

        // reset held 3 cycles, then one cycle of reset values
        repeat (3) begin
            @(negedge txclk);
            check("reset_outs", outs(), 0);
        end
        reset = 1'b0;
        #1 check("post_reset_outs", outs(), 0);
        wait_idle("t1_all_four");

        // single byte from req 2
        @(negedge txclk);
        give(2, 1, 8'hAA);
        push(4'b0100, 8'hAA);
        n = 0;
        do begin
            @(negedge txclk);
            n++;
        end while (!busy && n < 20);
        len = 0;
        while (busy && len < 60) begin
            len++;
            @(negedge txclk);
        end
        check("busy_len", len, 12);
        wait_idle("t2_single");

        // fairness from a fresh pointer
        do_reset();
        give(0, 2, 8'h00);
        give(1, 2, 8'h10);
        give(3, 2, 8'h30);
        push(4'b0001, 8'h00);
        push(4'b0010, 8'h10);
        push(4'b1000, 8'h30);
        push(4'b0001, 8'h01);
        push(4'b0010, 8'h11);
        push(4'b1000, 8'h31);
        wait_idle("t3_fairness");

        // timeout: tx_empty never falls
        stuck = 1'b1;
        give(1, 1, 8'h55);
        push(4'b0010, 8'h55);
        n = 0;
        do begin
            @(negedge txclk);
            n++;
        end while (!ld_tx_data && n < 20);
        cyc = 0;
        do begin
            @(negedge txclk);
            cyc++;
        end while (!err_timeout && cyc < 40);
        check("timeout_wait_cycles", cyc - 1, 15);
        check("timeout_idle", 32'(busy), 0);
        stuck = 1'b0;
        @(negedge txclk);
        give(2, 1, 8'h66);
        push(4'b0100, 8'h66);
        wait_idle("t4_after_timeout");
        check("err_sticky", 32'(err_timeout), 1);

        // sched_en drops mid-frame
        do_reset();
        check("err_cleared", 32'(err_timeout), 0);
        give(0, 1, 8'h77);
        push(4'b0001, 8'h77);
        wait_frame_start();
        repeat (3) @(negedge txclk);
        sched_en = 1'b0;
        give(1, 1, 8'h88);
        bad = 0;
        n = 0;
        while (!tx_empty && n < 40) begin
            if (!tx_enable) bad++;
            @(negedge txclk);
            n++;
        end
        check("tx_en_held", bad, 0);
        check("tx_en_at_rise", 32'(tx_enable), 1);
        @(negedge txclk);
        check("tx_en_off", 32'(tx_enable), 0);
        acks = 0;
        repeat (20) begin
            @(negedge txclk);
            if (req_ack != 4'd0) acks++;
        end
        check("ack_while_disabled", acks, 0);
        check("busy_while_disabled", 32'(busy), 0);
        sched_en = 1'b1;
        push(4'b0010, 8'h88);
        wait_idle("t5_reenable");

        // reset during WAIT_DONE, pointer was at 2
        give(1, 1, 8'hB1);
        give(2, 1, 8'hB2);
        give(3, 1, 8'hB3);
        push(4'b0100, 8'hB2);
        wait_frame_start();
        repeat (3) @(negedge txclk);
        reset = 1'b1;
        @(negedge txclk);
        check("reset_wait_done", outs(), 0);
        reset = 1'b0;
        push(4'b0010, 8'hB1);
        push(4'b1000, 8'hB3);
        wait_idle("t6_regrant");

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
